// File: rtl/jk_bank_arbiter.sv
// Bank of JK flip-flop cells shared by several requesters through a round-robin
// arbiter with an optional grant lock and a two-stage register/apply pipeline.
module jk_bank_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int NUM_FF  = 8,
   parameter int IDX_W   = 3,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_j,
   input  logic [NUM_REQ-1:0]       req_k,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   input  logic [NUM_REQ-1:0]       req_lock,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_FF-1:0]        q,
   output logic                     done,
   output logic [ID_W-1:0]          done_id,
   output logic                     err,
   output logic                     locked,
   output logic [ID_W-1:0]          lock_owner
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t             state_r, state_s;
   logic [ID_W-1:0]    rr_r, rr_s;
   logic [ID_W-1:0]    owner_r, owner_s;
   logic [ID_W-1:0]    win_s;
   logic               grant_s;
   logic               s1_valid_r;
   logic               s1_j_r, s1_k_r;
   logic [IDX_W-1:0]   s1_idx_r;
   logic [ID_W-1:0]    s1_id_r;
   logic [NUM_FF-1:0]  q_r, q_s;
   logic               in_range_s;
   logic               done_r, err_r;
   logic [ID_W-1:0]    done_id_r;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      if (int'(id) >= NUM_REQ - 1) begin
         return '0;
      end else begin
         return id + ID_W'(1);
      end
   endfunction

   // Winner selection; the downward scan leaves the first valid requester at or above rr_r in win_s.
   always_comb begin
      win_s   = '0;
      grant_s = 1'b0;
      case (state_r)
         ST_LOCKED: begin
            win_s   = owner_r;
            grant_s = req_valid[owner_r];
         end
         ST_IDLE: begin
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
               grant_s = grant_s | req_valid[(int'(rr_r) + off) % NUM_REQ];
               win_s   = req_valid[(int'(rr_r) + off) % NUM_REQ] ?
                         ID_W'((int'(rr_r) + off) % NUM_REQ) : win_s;
            end
         end
         default: begin
            win_s   = '0;
            grant_s = 1'b0;
         end
      endcase
   end

   // Ready is one-hot on the winner and forced low during reset.
   always_comb begin
      req_ready = '0;
      if (grant_s && reset_n) begin
         req_ready[win_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Lock FSM next state, round-robin pointer and lock owner.
   always_comb begin
      state_s = state_r;
      rr_s    = rr_r;
      owner_s = owner_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               rr_s = next_id(win_s);
               if (req_lock[win_s]) begin
                  state_s = ST_LOCKED;
                  owner_s = win_s;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (grant_s && !req_lock[win_s]) begin
               state_s = ST_IDLE;
               rr_s    = next_id(owner_r);
               owner_s = '0;
            end else begin
               state_s = ST_LOCKED;
            end
         end
         default: begin
            state_s = ST_IDLE;
            rr_s    = '0;
            owner_s = '0;
         end
      endcase
   end

   // JK apply on the commanded cell; out-of-range indices leave the bank untouched.
   always_comb begin
      q_s        = q_r;
      in_range_s = (int'(s1_idx_r) < NUM_FF);
      if (s1_valid_r && in_range_s) begin
         case ({s1_j_r, s1_k_r})
            2'b01:   q_s[s1_idx_r] = 1'b0;
            2'b10:   q_s[s1_idx_r] = 1'b1;
            2'b11:   q_s[s1_idx_r] = ~q_r[s1_idx_r];
            default: q_s[s1_idx_r] = q_r[s1_idx_r];
         endcase
      end else begin
         q_s = q_r;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         rr_r    <= '0;
         owner_r <= '0;
      end else begin
         state_r <= state_s;
         rr_r    <= rr_s;
         owner_r <= owner_s;
      end
   end

   // Stage 1: capture the accepted command.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_r <= 1'b0;
         s1_j_r     <= 1'b0;
         s1_k_r     <= 1'b0;
         s1_idx_r   <= '0;
         s1_id_r    <= '0;
      end else begin
         s1_valid_r <= grant_s;
         if (grant_s) begin
            s1_j_r   <= req_j[win_s];
            s1_k_r   <= req_k[win_s];
            s1_idx_r <= req_idx[int'(win_s)*IDX_W +: IDX_W];
            s1_id_r  <= win_s;
         end
      end
   end

   // Stage 2: bank update and completion report move together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r       <= '0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         done_id_r <= '0;
      end else begin
         q_r    <= q_s;
         done_r <= s1_valid_r;
         err_r  <= s1_valid_r && !in_range_s;
         if (s1_valid_r) begin
            done_id_r <= s1_id_r;
         end
      end
   end

   assign q          = q_r;
   assign done       = done_r;
   assign err        = err_r;
   assign done_id    = done_id_r;
   assign locked     = (state_r == ST_LOCKED);
   assign lock_owner = owner_r;

endmodule
